game_fsm: RTL

//  Parametrised game-state controller for the runner game; successor to the fixed 4-bit status logic.

---
 rtl/game_pkg.sv | 33 +++
 rtl/bcd_sat_adder.sv | 30 +++
 rtl/game_fsm.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the runner game-state controller.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PAUSED   = 2'd1,
    PLAYING  = 2'd2,
    GAMEOVER = 2'd3
  } game_state_t;

  localparam int unsigned ST_IDLE     = 0;
  localparam int unsigned ST_PAUSED   = 1;
  localparam int unsigned ST_PLAYING  = 2;
  localparam int unsigned ST_GAMEOVER = 3;

  localparam logic [7:0] KEY_START = 8'h28;
  localparam logic [7:0] KEY_PAUSE = 8'h13;

  // One-hot status vector for a given state
  function automatic logic [3:0] state_to_status(input game_state_t s);
    logic [3:0] st;
    st = '0;
    case (s)
      IDLE:     st[ST_IDLE]     = 1'b1;
      PAUSED:   st[ST_PAUSED]   = 1'b1;
      PLAYING:  st[ST_PLAYING]  = 1'b1;
      GAMEOVER: st[ST_GAMEOVER] = 1'b1;
      default:  st[ST_IDLE]     = 1'b1;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/bcd_sat_adder.sv
// Packed-BCD score plus a small binary increment; clamps to all nines on overflow.
module bcd_sat_adder #(
  parameter int unsigned SCORE_DIGITS = 4,
  parameter int unsigned INC_W        = 3
) (
  input  logic [4*SCORE_DIGITS-1:0] a,
  input  logic [INC_W-1:0]          inc,
  output logic [4*SCORE_DIGITS-1:0] sum_c
);

  localparam int unsigned SW = INC_W + 5;

  logic [SW-1:0]             carry;
  logic [SW-1:0]             dsum;
  logic [4*SCORE_DIGITS-1:0] raw;

  // Ripple the increment through the digits, least significant first
  always_comb begin
    carry = SW'(inc);
    dsum  = '0;
    raw   = '0;
    for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
      dsum            = SW'(a[4*i +: 4]) + carry;
      raw[4*i +: 4]   = 4'(dsum % SW'(10));
      carry           = dsum / SW'(10);
    end
    sum_c = (carry != '0) ? {SCORE_DIGITS{4'h9}} : raw;
  end

endmodule

// File: rtl/game_fsm.sv
// Runner game-state controller: per-frame score, lives, invulnerability and speed.
// Optional high-score register enabled by defining GAME_FSM_HISCORE_EN.
module game_fsm
  import game_pkg::*;
#(
  parameter int unsigned NUM_OBJ       = 4,
  parameter int unsigned SCORE_DIGITS  = 4,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned DIST_FRAMES   = 30,
  parameter int unsigned LEVEL_FRAMES  = 600,
  parameter int unsigned MAX_LEVEL     = 7,
  parameter logic [9:0]  FALL_MARGIN   = 10'd8
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_clk,
  input  logic [7:0]                keycode,
  input  logic [NUM_OBJ-1:0]        hit,
  input  logic [NUM_OBJ-1:0]        coin,
  input  logic [9:0]                StickmanBottom,
  input  logic [9:0]                GroundY,
  output logic [3:0]                status,
  output logic [4*SCORE_DIGITS-1:0] score,
  output logic [2:0]                lives,
  output logic [2:0]                speed_level,
  output logic                      frame_tick,
  output logic                      invuln,
  output logic [4*SCORE_DIGITS-1:0] hiscore
);

  localparam int unsigned SW     = 4 * SCORE_DIGITS;
  localparam int unsigned INC_W  = $clog2(NUM_OBJ + 2);
  localparam int unsigned DIST_W = $clog2(DIST_FRAMES + 1);
  localparam int unsigned LVL_W  = $clog2(LEVEL_FRAMES + 1);
  localparam int unsigned INV_W  = $clog2(INVULN_FRAMES + 1);

  game_state_t       state_q, state_d;
  logic [7:0]        key_prev_q, key_prev_d;
  logic [2:0]        fsync_q, fsync_d;
  logic              frame_tick_q, frame_tick_d;
  logic [3:0]        status_q, status_d;
  logic [SW-1:0]     score_q, score_d;
  logic [2:0]        lives_q, lives_d;
  logic [2:0]        speed_q, speed_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic [INV_W-1:0]  inv_q, inv_d;
  logic              invuln_q, invuln_d;

  logic              start_c, pause_c, dist_wrap_c, death_c;
  logic [INC_W-1:0]  inc_c;
  logic [SW-1:0]     score_sum_c;

  // Frame-event inputs: coin popcount plus distance bonus, and death detection
  always_comb begin
    start_c     = (keycode != key_prev_q) && (keycode == KEY_START);
    pause_c     = (keycode != key_prev_q) && (keycode == KEY_PAUSE);
    dist_wrap_c = (dist_q == DIST_W'(DIST_FRAMES - 1));
    inc_c       = INC_W'(dist_wrap_c);
    for (int i = 0; i < int'(NUM_OBJ); i++) begin
      inc_c = inc_c + INC_W'(coin[i]);
    end
    // 11-bit compare so a ground line near the bottom cannot wrap the margin
    death_c = (|hit) ||
              ({1'b0, StickmanBottom} > ({1'b0, GroundY} + 11'(FALL_MARGIN)));
  end

  bcd_sat_adder #(
    .SCORE_DIGITS(SCORE_DIGITS),
    .INC_W       (INC_W)
  ) u_score_add (
    .a    (score_q),
    .inc  (inc_c),
    .sum_c(score_sum_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    key_prev_d   = keycode;
    fsync_d      = {fsync_q[1:0], frame_clk};
    frame_tick_d = fsync_q[1] & ~fsync_q[2];
    score_d      = score_q;
    lives_d      = lives_q;
    speed_d      = speed_q;
    dist_d       = dist_q;
    lvl_d        = lvl_q;
    inv_d        = inv_q;

    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = PLAYING;
          score_d = '0;
          lives_d = 3'(LIVES);
          speed_d = '0;
          dist_d  = '0;
          lvl_d   = '0;
          inv_d   = '0;
        end
      end
      PLAYING: begin
        // A key press in the tick cycle swallows that frame
        if (pause_c) begin
          state_d = PAUSED;
        end else if (frame_tick_q && !start_c) begin
          score_d = score_sum_c;
          dist_d  = dist_wrap_c ? '0 : dist_q + DIST_W'(1);
          if (lvl_q == LVL_W'(LEVEL_FRAMES - 1)) begin
            lvl_d = '0;
            if (speed_q < 3'(MAX_LEVEL)) speed_d = speed_q + 3'd1;
          end else begin
            lvl_d = lvl_q + LVL_W'(1);
          end
          if (death_c && (inv_q == '0)) begin
            lives_d = lives_q - 3'd1;
            inv_d   = INV_W'(INVULN_FRAMES - 1);
          end else if (inv_q != '0) begin
            inv_d = inv_q - INV_W'(1);
          end
          if (lives_d == 3'd0) state_d = GAMEOVER;
        end
      end
      PAUSED: begin
        if (pause_c || start_c) state_d = PLAYING;
      end
      GAMEOVER: begin
        if (start_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    status_d = state_to_status(state_d);
    invuln_d = (inv_d != '0);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      key_prev_q   <= '0;
      fsync_q      <= '0;
      frame_tick_q <= 1'b0;
      status_q     <= 4'b0001;
      score_q      <= '0;
      lives_q      <= 3'(LIVES);
      speed_q      <= '0;
      dist_q       <= '0;
      lvl_q        <= '0;
      inv_q        <= '0;
      invuln_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_prev_q   <= key_prev_d;
      fsync_q      <= fsync_d;
      frame_tick_q <= frame_tick_d;
      status_q     <= status_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      speed_q      <= speed_d;
      dist_q       <= dist_d;
      lvl_q        <= lvl_d;
      inv_q        <= inv_d;
      invuln_q     <= invuln_d;
    end
  end

  assign status      = status_q;
  assign score       = score_q;
  assign lives       = lives_q;
  assign speed_level = speed_q;
  assign frame_tick  = frame_tick_q;
  assign invuln      = invuln_q;

`ifdef GAME_FSM_HISCORE_EN
  logic [SW-1:0] hiscore_q, hiscore_d;

  // Packed BCD orders the same as unsigned binary, so a plain compare suffices
  always_comb begin
    hiscore_d = hiscore_q;
    if ((state_q != GAMEOVER) && (state_d == GAMEOVER) && (score_d > hiscore_q))
      hiscore_d = score_d;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) hiscore_q <= '0;
    else          hiscore_q <= hiscore_d;
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = '0;
`endif

endmodule
